// File: rtl/cpu_execution_result_stage_if.sv
// Execute-to-memory bus: upstream ALU beat plus the downstream record handshake.
// The slave modport is the result stage itself; master is the surrounding pipeline.
interface cpu_execution_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_badfunct;
    logic [31:0] in_pc;
    logic [4:0]  in_dest;
    logic        in_wen;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [31:0] in_store_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [31:0] out_store_data;
    logic [31:0] out_pc;
    logic        out_exc;
    logic [4:0]  out_exccode;

    modport master (
        output in_valid, alu_result, alu_overflow, alu_badfunct, in_pc, in_dest,
               in_wen, in_mem_read, in_mem_write, in_store_data, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_wen, out_mem_read,
               out_mem_write, out_store_data, out_pc, out_exc, out_exccode
    );

    modport slave (
        input  in_valid, alu_result, alu_overflow, alu_badfunct, in_pc, in_dest,
               in_wen, in_mem_read, in_mem_write, in_store_data, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_wen, out_mem_read,
               out_mem_write, out_store_data, out_pc, out_exc, out_exccode
    );
endinterface

// File: rtl/cpu_execution_result_stage.sv
// Execute-to-memory pipeline register: captures ALU results, turns ALU faults into a
// precise exception record, and blocks younger beats until flushed.
module cpu_execution_result_stage #(
    parameter logic [4:0] EXC_RI = 5'h0A,
    parameter logic [4:0] EXC_OV = 5'h0C
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    cpu_execution_result_stage_if.slave        bus,
    output logic                               fwd_valid,
    output logic [4:0]                         fwd_dest,
    output logic [31:0]                        fwd_data,
    output logic                               halted
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        in_ready_s;
    logic        load_s;
    logic        drain_s;
    logic        fault_s;

    logic        out_valid_r;
    logic [31:0] out_result_r;
    logic [4:0]  out_dest_r;
    logic        out_wen_r;
    logic        out_mem_read_r;
    logic        out_mem_write_r;
    logic [31:0] out_store_data_r;
    logic [31:0] out_pc_r;
    logic        out_exc_r;
    logic [4:0]  out_exccode_r;

    // Reserved-instruction outranks overflow when both flags are raised.
    function automatic logic [4:0] exc_code_f(input logic badfunct, input logic overflow);
        logic [4:0] code;
        case ({badfunct, overflow})
            2'b10, 2'b11: code = EXC_RI;
            2'b01:        code = EXC_OV;
            default:      code = 5'h00;
        endcase
        return code;
    endfunction

    // Handshake qualification and next-state selection.
    always_comb begin
        in_ready_s   = 1'b1;
        next_state_s = state_r;
        drain_s      = out_valid_r & bus.out_ready;
        fault_s      = bus.in_valid & (bus.alu_badfunct | bus.alu_overflow);
        case (state_r)
            ST_EMPTY: in_ready_s = 1'b1;
            ST_FULL:  in_ready_s = ~out_valid_r | bus.out_ready;
            ST_HALT:  in_ready_s = 1'b1;
            default:  in_ready_s = 1'b1;
        endcase
        load_s = bus.in_valid & in_ready_s & ~flush & (state_r != ST_HALT);
        if (flush) begin
            next_state_s = ST_EMPTY;
        end else if (load_s) begin
            next_state_s = fault_s ? ST_HALT : ST_FULL;
        end else if (drain_s && (state_r != ST_HALT)) begin
            next_state_s = ST_EMPTY;
        end else begin
            next_state_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Record register; payload holds across a drain so debug can still inspect it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r      <= 1'b0;
            out_result_r     <= 32'h0000_0000;
            out_dest_r       <= 5'd0;
            out_wen_r        <= 1'b0;
            out_mem_read_r   <= 1'b0;
            out_mem_write_r  <= 1'b0;
            out_store_data_r <= 32'h0000_0000;
            out_pc_r         <= 32'h0000_0000;
            out_exc_r        <= 1'b0;
            out_exccode_r    <= 5'd0;
        end else if (flush) begin
            out_valid_r      <= 1'b0;
            out_exc_r        <= 1'b0;
            out_exccode_r    <= 5'd0;
        end else if (load_s) begin
            out_valid_r      <= 1'b1;
            out_result_r     <= bus.alu_result;
            out_dest_r       <= bus.in_dest;
            out_wen_r        <= bus.in_wen & ~fault_s;
            out_mem_read_r   <= bus.in_mem_read & ~fault_s;
            out_mem_write_r  <= bus.in_mem_write & ~fault_s;
            out_store_data_r <= bus.in_store_data;
            out_pc_r         <= bus.in_pc;
            out_exc_r        <= fault_s;
            out_exccode_r    <= exc_code_f(bus.alu_badfunct, bus.alu_overflow);
        end else if (drain_s) begin
            out_valid_r      <= 1'b0;
        end
    end

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_r;
    assign bus.out_result     = out_result_r;
    assign bus.out_dest       = out_dest_r;
    assign bus.out_wen        = out_wen_r;
    assign bus.out_mem_read   = out_mem_read_r;
    assign bus.out_mem_write  = out_mem_write_r;
    assign bus.out_store_data = out_store_data_r;
    assign bus.out_pc         = out_pc_r;
    assign bus.out_exc        = out_exc_r;
    assign bus.out_exccode    = out_exccode_r;

    // Forwarding reads registers only; r0 writes never forward.
    assign fwd_valid = out_valid_r & out_wen_r & (out_dest_r != 5'd0);
    assign fwd_dest  = out_dest_r;
    assign fwd_data  = out_result_r;
    assign halted    = (state_r == ST_HALT);

endmodule

// File: doc/cpu_execution_result_stage.md
Name: cpu_execution_result_stage

Overview:
- Execute-to-memory pipeline register. Sits directly downstream of the execution ALU.
- Captures the ALU result, overflow and bad-function flags with the instruction's sideband, and converts ALU faults into a precise exception record.
- Presents the record to the memory stage over a valid/ready handshake.
- Drives a same-cycle forwarding tap back to the operand-select logic.
- After a fault, blocks all younger instructions until the pipeline is flushed.

Parameters:
- EXC_RI, 5'h0A, exception code reported for alu_badfunct (reserved instruction)
- EXC_OV, 5'h0C, exception code reported for alu_overflow (arithmetic overflow)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held record and leave HALT; has priority over everything except rst
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- alu_result  in  32  ALU result
- alu_overflow  in  1  ALU overflow flag
- alu_badfunct  in  1  ALU illegal-function flag
- in_pc  in  32  PC of instruction
- in_dest  in  5  destination register index
- in_wen  in  1  register write enable
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_store_data  in  32  store data
- out_valid  out  1  record held for memory stage
- out_ready  in  1  memory stage accepts record
- out_result  out  32  registered result / address
- out_dest  out  5  registered destination
- out_wen  out  1  registered write enable (0 on exception)
- out_mem_read  out  1  registered load (0 on exception)
- out_mem_write  out  1  registered store (0 on exception)
- out_store_data  out  32  registered store data
- out_pc  out  32  registered PC (EPC on exception)
- out_exc  out  1  record is an exception
- out_exccode  out  5  exception code, 0 when out_exc=0
- fwd_valid  out  1  out_valid & out_wen & (out_dest != 0)
- fwd_dest  out  5  equals out_dest
- fwd_data  out  32  equals out_result
- halted  out  1  state == HALT

Behaviour:
- States: EMPTY, FULL, HALT (HALT means an exception record was loaded; no younger beat may be recorded).
- Reset (rst=1 at edge):
  - State becomes EMPTY.
  - All out_* fields and fwd_* become 0; halted becomes 0.
  - Reset mid-transfer drops the held record.
- in_ready:
  - EMPTY: 1.
  - FULL: !out_valid | out_ready (single-slot pipe; accept while draining).
  - HALT: 1 (beats are consumed and discarded, never recorded).
- Load condition: in_valid & in_ready & !flush & state != HALT.
  - On load: out_valid <= 1; every field is registered from its input; state <= FULL.
  - Latency is 1 cycle from an accepted beat to out_valid.
- Exception qualification at load:
  - Only computed when in_valid=1.
  - alu_badfunct has priority over alu_overflow.
  - If either flag is set:
    - out_exc=1, out_exccode = EXC_RI or EXC_OV.
    - out_wen, out_mem_read and out_mem_write are forced to 0.
    - out_result still takes alu_result, for debug.
    - out_pc = in_pc.
    - State <= HALT instead of FULL.
  - Otherwise out_exc=0 and out_exccode=0.
- Drain (out_valid & out_ready with no load the same cycle):
  - out_valid <= 0.
  - State: FULL -> EMPTY; HALT stays HALT.
  - Payload fields hold their last values.
- Simultaneous drain and load in FULL: the new record replaces the old one with no bubble; out_valid stays 1.
- HALT:
  - The exception record is held until drained.
  - Afterwards out_valid=0 and incoming beats are dropped.
  - Only flush or rst leaves HALT.
- flush=1 at an edge:
  - out_valid <= 0, out_exc <= 0, state <= EMPTY.
  - A concurrent in_valid beat is discarded (flush wins over load).
  - A concurrent out_ready is irrelevant, because the record is killed.
- Forwarding outputs are combinational from registers only; there is no in_* to fwd_* path.
- Dest 0 writes pass through on out_wen but never forward.
- Stores are not qualified against in_dest.

Test Plan:
- Back-to-back stream, out_ready=1:
  - Stimulus: 4 beats with alu_result 1,2,3,4, dest 5, wen=1.
  - Required: out_valid every cycle from cycle 1 onward; results 1..4 in order; fwd_valid=1 with fwd_data tracking the result.
- Backpressure:
  - Stimulus: out_ready=0 while FULL.
  - Required: in_ready=0; record 0xDEADBEEF held stable for 3 cycles.
  - Then out_ready=1 with in_valid: next beat 0x12345678 appears with no bubble.
- Overflow beat:
  - Stimulus: alu_overflow=1, in_pc=0x00400010, wen=1.
  - Required: out_exc=1, out_exccode=0x0C, out_wen=0, out_pc=0x00400010, halted=1.
  - The following two beats are accepted (in_ready=1) but never appear.
- Flag priority:
  - Stimulus: alu_badfunct=1 and alu_overflow=1 together.
  - Required: out_exccode=0x0A.
- Flush while HALT and an in_valid beat present in the same cycle:
  - Required: next cycle out_valid=0, halted=0, state EMPTY.
  - A beat offered one cycle later is recorded normally.
- Reset mid-record:
  - Stimulus: FULL with out_ready=0, then rst=1 for one cycle.
  - Required: all outputs 0, in_ready=1; fwd_valid=0 even if dest was nonzero.
  - Also: a record with dest 0 gives fwd_valid=0.
